// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status flowing in from ID/EX and the
// write-enable / bubble controls flowing back out to the pipeline registers.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_muldiv_start;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        ifid_flush;
  logic        bubble_sel;
  logic        exmem_bubble;
  logic        md_last;
  logic        busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, ex_muldiv_start,
    input  pc_write, ifid_write, idex_write, ifid_flush, bubble_sel, exmem_bubble,
           md_last, busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, ex_muldiv_start,
    output pc_write, ifid_write, idex_write, ifid_flush, bubble_sel, exmem_bubble,
           md_last, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use stalls, taken-branch
// squash, and a front-end freeze while a multi-cycle mul/div sits in EX.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  hazard_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES);
  // The start cycle and the md_last cycle are not counted, hence the -2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic {RUN, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      stall_cnt;

  logic pc_write, ifid_write, idex_write;
  logic ifid_flush, bubble_sel, exmem_bubble, md_last;
  logic load_use;

  // Saturating increment so a long stall never wraps the counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Load whose destination is a live source of the instruction in ID.
  assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // FSM state and mul/div down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and pipeline control decode; branch beats mul/div beats load-use.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    bubble_sel   = 1'b0;
    exmem_bubble = 1'b0;
    md_last      = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ifid_flush = 1'b1;
          bubble_sel = 1'b1;
        end else if (hz.ex_muldiv_start) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          state_nxt    = BUSY;
          cnt_nxt      = CNT_LOAD;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble_sel = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          cnt_nxt      = cnt - CNT_W'(1);
        end else begin
          md_last   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Count every edge at which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_write   = idex_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.bubble_sel   = bubble_sel;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.md_last      = md_last;
  assign hz.busy         = (state == BUSY);
  assign hz.stall_cnt    = stall_cnt;

endmodule
